mul_arbiter: RTL

Round-robin arbiter and sequencer that shares one 4x4 sequential multiplier (seq_mul: start/a/b in, 8-bit op out) among N_REQ requesters. It grants one requester, latches its operands and pulses the multiplier start. It waits a fixed latency, captures the product and returns it with a one-cycle done pulse to the winner. It sits between client blocks and the seq_mul instance and is the only driver of the multiplier's start, a and b inputs.

---
 rtl/mul_arbiter_if.sv | 27 ++
 rtl/mul_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mul_arbiter_if.sv
// Client/multiplier-side bundle of the shared 4x4 multiplier arbiter.
// master = clients plus seq_mul, slave = the arbiter.
interface mul_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [4*N_REQ-1:0] a_in;
  logic [4*N_REQ-1:0] b_in;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   done;
  logic [7:0]         result;
  logic               busy;
  logic               mul_start;
  logic [3:0]         mul_a;
  logic [3:0]         mul_b;
  logic [7:0]         mul_op;

  modport master (
    output req, a_in, b_in, mul_op,
    input  gnt, done, result, busy, mul_start, mul_a, mul_b
  );

  modport slave (
    input  req, a_in, b_in, mul_op,
    output gnt, done, result, busy, mul_start, mul_a, mul_b
  );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one sequential 4x4 multiplier among
// N_REQ clients: grant, pulse start, wait MUL_LAT edges, capture, pulse done.
module mul_arbiter_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       win,
  input  logic       take,
  input  logic       fin,
  input  logic       clr,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] a_sel,
  output logic [3:0] b_sel,
  output logic       gnt,
  output logic       done
);
  // Non-winning lanes contribute zero so the operand mux is a plain OR.
  assign a_sel = win ? a : 4'd0;
  assign b_sel = win ? b : 4'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt  <= 1'b0;
      done <= 1'b0;
    end else if (clr) begin
      gnt  <= 1'b0;
      done <= 1'b0;
    end else begin
      if (take && win) gnt  <= 1'b1;
      if (fin && gnt)  done <= 1'b1;
    end
  end
endmodule

module mul_arbiter #(
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mul_arbiter_if.slave bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t                  state;
  logic [IW-1:0]           ptr, idx, win_idx;
  logic [3:0]              cnt;
  logic [N_REQ-1:0]        win_oh, gnt_v, done_v;
  logic [N_REQ-1:0][3:0]   a_sel, b_sel;
  logic [3:0]              a_pick, b_pick;
  logic                    any_req, take, fin, clr;

  // First requester found scanning ptr+1, ptr+2, ... modulo N_REQ.
  always_comb begin : rr_search
    logic [IW:0] sum;
    logic        found;
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    sum     = '0;
    for (int s = 1; s <= N_REQ; s++) begin
      sum = {1'b0, ptr} + (IW+1)'(s);
      if (sum >= (IW+1)'(N_REQ)) sum = sum - (IW+1)'(N_REQ);
      if (!found && bus.req[sum[IW-1:0]]) begin
        found                = 1'b1;
        win_idx              = sum[IW-1:0];
        win_oh[sum[IW-1:0]]  = 1'b1;
      end
    end
  end

  assign any_req = |bus.req;
  assign take    = (state == IDLE) && any_req;
  assign fin     = (state == WAIT) && (cnt == 4'd0);
  assign clr     = (state == DONE);

  genvar g;
  generate
    for (g = 0; g < N_REQ; g++) begin : g_lane
      mul_arbiter_lane u_lane (
        .clk   (clk),
        .rst_n (rst_n),
        .win   (win_oh[g]),
        .take  (take),
        .fin   (fin),
        .clr   (clr),
        .a     (bus.a_in[4*g +: 4]),
        .b     (bus.b_in[4*g +: 4]),
        .a_sel (a_sel[g]),
        .b_sel (b_sel[g]),
        .gnt   (gnt_v[g]),
        .done  (done_v[g])
      );
    end
  endgenerate

  always_comb begin
    a_pick = '0;
    b_pick = '0;
    for (int i = 0; i < N_REQ; i++) begin
      a_pick = a_pick | a_sel[i];
      b_pick = b_pick | b_sel[i];
    end
  end

  assign bus.gnt  = gnt_v;
  assign bus.done = done_v;

  // mul_a/mul_b double as the operand latch: loaded at grant, shown only in START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= IW'(N_REQ-1);
      idx           <= '0;
      cnt           <= '0;
      bus.result    <= '0;
      bus.busy      <= 1'b0;
      bus.mul_start <= 1'b0;
      bus.mul_a     <= '0;
      bus.mul_b     <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          idx           <= win_idx;
          bus.mul_a     <= a_pick;
          bus.mul_b     <= b_pick;
          bus.mul_start <= 1'b1;
          bus.busy      <= 1'b1;
          state         <= START;
        end
        START: begin
          bus.mul_start <= 1'b0;
          bus.mul_a     <= '0;
          bus.mul_b     <= '0;
          cnt           <= 4'(MUL_LAT-1);
          state         <= WAIT;
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            bus.result <= bus.mul_op;
            state      <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          ptr      <= idx;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
